// File: rtl/mem_access_sequencer_if.sv
// Request/response handshake between a load-store master and mem_access_sequencer.
// The master drives single-word requests; the sequencer returns read data with a one-cycle strobe.
interface mem_access_sequencer_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W:0]   req_addr;   // MSB is the block select
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/mem_access_sequencer.sv
// Initiator for the two-block memory enable code: turns single read/write requests into
// {block_sel, write} codes, waits out the block read latency and returns the selected word.
module mem_access_sequencer #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  mem_access_sequencer_if.slave host,
  output logic [1:0]            memoryena,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     block1_rdata,
  input  logic [DATA_W-1:0]     block2_rdata,
  output logic                  busy
);

  if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_rd_lat
    $error("mem_access_sequencer: RD_LAT must be 1..3");
  end

  localparam logic [1:0] RD_LAT_CNT = 2'(RD_LAT);

  typedef enum logic [1:0] {IDLE, WRITE, RD, RESP} state_t;

  state_t            state, state_d;
  logic [1:0]        memoryena_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;
  logic              sel_q, sel_d;
  logic [1:0]        cnt, cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              accept;

  // Only the read wait blocks new requests; a write or response cycle can hand over directly.
  assign host.req_ready = (state != RD);
  assign busy           = (state != IDLE);
  assign accept         = host.req_valid && host.req_ready;

  assign host.rsp_valid = rsp_valid_q;
  assign host.rsp_rdata = rsp_rdata_q;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d     = state;
    memoryena_d = memoryena;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    sel_d       = sel_q;
    cnt_d       = cnt;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;

    unique case (state)
      IDLE, WRITE, RESP: begin
        // 2'b00 (block1 read) is the side-effect-free idle code; the decoder has no true no-op.
        state_d     = IDLE;
        memoryena_d = 2'b00;
        if (accept) begin
          sel_d       = host.req_addr[ADDR_W];
          mem_addr_d  = host.req_addr[ADDR_W-1:0];
          memoryena_d = {host.req_addr[ADDR_W], host.req_write};
          if (host.req_write) begin
            mem_wdata_d = host.req_wdata;
            state_d     = WRITE;
          end else begin
            cnt_d   = RD_LAT_CNT;
            state_d = RD;
          end
        end
      end
      RD: begin
        if (cnt == 2'd0) begin
          // Registered select: req_addr may already carry the next request.
          rsp_rdata_d = sel_q ? block2_rdata : block1_rdata;
          rsp_valid_d = 1'b1;
          memoryena_d = 2'b00;
          state_d     = RESP;
        end else begin
          cnt_d = cnt - 2'd1;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      memoryena   <= 2'b00;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      sel_q       <= 1'b0;
      cnt         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state       <= state_d;
      memoryena   <= memoryena_d;
      mem_addr    <= mem_addr_d;
      mem_wdata   <= mem_wdata_d;
      sel_q       <= sel_d;
      cnt         <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

endmodule
